// File: rtl/div_sched_pkg.sv
// Shared types and defaults for the shared divide scheduler.
// Lane-index width helper keeps the grant pointer at least one bit wide.
package div_sched_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_CALC,
      ST_FIX,
      ST_RESP
   } state_t;

   localparam int DEF_WIDTH = 64;
   localparam int DEF_N_REQ = 4;

   function automatic int lane_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/div_core.sv
// Unsigned restoring divider: one quotient bit per cycle, MSB first.
// o_done is high during the cycle whose edge retires the final bit.
module div_core #(
   parameter int WIDTH = 64
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_start,
   input  logic [WIDTH-1:0] i_num,
   input  logic [WIDTH-1:0] i_den,
   output logic             o_done,
   output logic [WIDTH-1:0] o_quo
);

   localparam int CNT_W = (WIDTH <= 2) ? 1 : $clog2(WIDTH);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

   logic             r_run;
   logic [CNT_W-1:0] r_cnt;
   logic [WIDTH-1:0] r_rem;
   logic [WIDTH-1:0] r_quo;
   logic [WIDTH-1:0] r_den;

   logic [WIDTH:0]   w_shift;
   logic [WIDTH:0]   w_diff;
   logic             w_bit;
   logic [WIDTH-1:0] w_rem_next;

   // Remainder stays below the divisor, so the shifted value needs one extra bit.
   always_comb begin
      w_shift    = {r_rem, r_quo[WIDTH-1]};
      w_diff     = w_shift - {1'b0, r_den};
      w_bit      = ~w_diff[WIDTH];
      w_rem_next = w_bit ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_run <= 1'b0;
         r_cnt <= '0;
      end else if (i_start) begin
         r_run <= 1'b1;
         r_cnt <= '0;
      end else if (r_run) begin
         r_cnt <= r_cnt + CNT_W'(1);
         if (r_cnt == LAST)
            r_run <= 1'b0;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_start) begin
         r_rem <= '0;
         r_quo <= i_num;
         r_den <= i_den;
      end else if (r_run) begin
         r_rem <= w_rem_next;
         r_quo <= {r_quo[WIDTH-2:0], w_bit};
      end
   end

   assign o_done = r_run && (r_cnt == LAST);
   assign o_quo  = r_quo;

endmodule

// File: rtl/div_scheduler.sv
// Round-robin front end sharing one iterative signed divider among N_REQ lanes.
// Handles grant, sign folding, zero-divisor bypass and the held response.
module div_scheduler
   import div_sched_pkg::*;
#(
   parameter int N_REQ = DEF_N_REQ,
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic                     CLK,
   input  logic                     RESET,
   input  logic [N_REQ-1:0]         req_valid,
   output logic [N_REQ-1:0]         req_ready,
   input  logic [N_REQ*WIDTH-1:0]   req_num,
   input  logic [N_REQ*WIDTH-1:0]   req_den,
   output logic [N_REQ-1:0]         rsp_valid,
   input  logic [N_REQ-1:0]         rsp_ready,
   output logic signed [WIDTH-1:0]  rsp_quotient,
   output logic                     rsp_div_by_zero,
   output logic                     busy
);

   localparam int LANE_W = lane_w(N_REQ);
   localparam logic [LANE_W:0]    N_L = (LANE_W + 1)'(N_REQ);
   localparam logic [N_REQ-1:0]   ONE = N_REQ'(1);
   localparam logic [LANE_W-1:0]  LAST_LANE = LANE_W'(N_REQ - 1);

   function automatic logic [WIDTH-1:0] mag(input logic signed [WIDTH-1:0] v);
      return v[WIDTH-1] ? WIDTH'(-v) : WIDTH'(v);
   endfunction

   function automatic logic signed [WIDTH-1:0] apply_sign(input logic [WIDTH-1:0] m,
                                                          input logic neg);
      return neg ? signed'(WIDTH'(-m)) : signed'(m);
   endfunction

   state_t                    r_state;
   state_t                    w_next;
   logic [LANE_W-1:0]         r_rr_ptr;
   logic [LANE_W-1:0]         r_lane;
   logic                      r_neg;
   logic                      r_dbz;
   logic signed [WIDTH-1:0]   r_rsp_quo;

   logic [N_REQ-1:0]          w_rot;
   logic [LANE_W-1:0]         w_off;
   logic [LANE_W:0]           w_sum;
   logic [LANE_W-1:0]         w_grant_idx;
   logic [N_REQ-1:0]          w_grant_oh;
   logic                      w_accept;
   logic signed [WIDTH-1:0]   w_num;
   logic signed [WIDTH-1:0]   w_den;
   logic                      w_den_zero;
   logic                      w_core_start;
   logic                      w_core_done;
   logic [WIDTH-1:0]          w_core_quo;

   // Rotate requests so the search starts at rr_ptr; lowest set bit wins.
   always_comb begin
      w_rot = N_REQ'({req_valid, req_valid} >> r_rr_ptr);
      w_off = '0;
      for (int k = N_REQ - 1; k >= 0; k--)
         if (w_rot[k])
            w_off = LANE_W'(k);
      w_sum       = {1'b0, r_rr_ptr} + {1'b0, w_off};
      w_grant_idx = (w_sum >= N_L) ? LANE_W'(w_sum - N_L) : LANE_W'(w_sum);
      w_grant_oh  = ONE << w_grant_idx;
      w_accept    = (r_state == ST_IDLE) && !RESET && (|req_valid);
   end

   always_comb begin
      w_num = '0;
      w_den = '0;
      for (int k = 0; k < N_REQ; k++)
         if (w_grant_idx == LANE_W'(k)) begin
            w_num = req_num[k*WIDTH +: WIDTH];
            w_den = req_den[k*WIDTH +: WIDTH];
         end
      w_den_zero   = (w_den == '0);
      w_core_start = w_accept && !w_den_zero;
   end

   div_core #(
      .WIDTH (WIDTH)
   ) u_core (
      .i_clk   (CLK),
      .i_rst   (RESET),
      .i_start (w_core_start),
      .i_num   (mag(w_num)),
      .i_den   (mag(w_den)),
      .o_done  (w_core_done),
      .o_quo   (w_core_quo)
   );

   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE: if (w_accept) w_next = w_den_zero ? ST_RESP : ST_CALC;
         ST_CALC: if (w_core_done) w_next = ST_FIX;
         ST_FIX:  w_next = ST_RESP;
         ST_RESP: if (rsp_ready[r_lane]) w_next = ST_IDLE;
         default: w_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         r_state  <= ST_IDLE;
         r_rr_ptr <= '0;
      end else begin
         r_state <= w_next;
         if (w_accept)
            r_rr_ptr <= (w_grant_idx == LAST_LANE) ? '0 : w_grant_idx + LANE_W'(1);
      end
   end

   // Data path: lane/sign captured at grant, quotient sign-corrected in FIX.
   always_ff @(posedge CLK) begin
      if (w_accept) begin
         r_lane <= w_grant_idx;
         r_neg  <= w_num[WIDTH-1] ^ w_den[WIDTH-1];
         r_dbz  <= w_den_zero;
         if (w_den_zero)
            r_rsp_quo <= '0;
      end
      if (r_state == ST_FIX)
         r_rsp_quo <= apply_sign(w_core_quo, r_neg);
   end

   assign req_ready       = w_accept ? w_grant_oh : '0;
   assign rsp_valid       = (r_state == ST_RESP) ? (ONE << r_lane) : '0;
   assign rsp_quotient    = (r_state == ST_RESP) ? r_rsp_quo : '0;
   assign rsp_div_by_zero = (r_state == ST_RESP) && r_dbz;
   assign busy            = (r_state != ST_IDLE);

endmodule

// File: tb/tb_div_scheduler.sv
// Scoreboard bench for div_scheduler: stimulus queues expected responses,
// a negedge monitor matches each rising response against the queue head.
module tb_div_scheduler;

   localparam int N = 4;
   localparam int W = 64;
   localparam logic [W-1:0] MIN  = 64'h8000_0000_0000_0000;
   localparam logic [W-1:0] NEG1 = 64'hFFFF_FFFF_FFFF_FFFF;

   typedef struct {
      int         lane;
      logic [W-1:0] q;
      logic       dbz;
      int         lat;
   } exp_t;

   logic                  CLK = 1'b0;
   logic                  RESET;
   logic [N-1:0]          req_valid;
   logic [N-1:0]          req_ready;
   logic [N*W-1:0]        req_num;
   logic [N*W-1:0]        req_den;
   logic [N-1:0]          rsp_valid;
   logic [N-1:0]          rsp_ready;
   logic signed [W-1:0]   rsp_quotient;
   logic                  rsp_div_by_zero;
   logic                  busy;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_errors = 0;
   int   cyc = 0;
   int   acc_cyc = 0;

   div_scheduler #(.N_REQ(N), .WIDTH(W)) dut (
      .CLK             (CLK),
      .RESET           (RESET),
      .req_valid       (req_valid),
      .req_ready       (req_ready),
      .req_num         (req_num),
      .req_den         (req_den),
      .rsp_valid       (rsp_valid),
      .rsp_ready       (rsp_ready),
      .rsp_quotient    (rsp_quotient),
      .rsp_div_by_zero (rsp_div_by_zero),
      .busy            (busy)
   );

   always #5 CLK = ~CLK;
   always @(posedge CLK) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] req);
      n_checks++;
      if (act !== req) begin
         n_errors++;
         $display("FAIL %s: got %0h required %0h", nm, act, req);
      end
   endtask

   task automatic timeout(input string nm);
      n_checks++;
      n_errors++;
      $display("FAIL %s: timed out at cycle %0d", nm, cyc);
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge CLK);
      #1;
   endtask

   task automatic push(input int lane, input logic [W-1:0] q, input logic dbz);
      exp_t e;
      e.lane = lane; e.q = q; e.dbz = dbz; e.lat = dbz ? 1 : W + 2;
      exp_q.push_back(e);
   endtask

   // Present one operand pair on a lane until granted, then drop it.
   task automatic issue(input int lane, input logic [W-1:0] num, input logic [W-1:0] den,
                        input logic [W-1:0] q, input logic dbz, input bit do_push);
      bit got;
      got = 1'b0;
      req_num[lane*W +: W] = num;
      req_den[lane*W +: W] = den;
      req_valid[lane] = 1'b1;
      if (do_push) push(lane, q, dbz);
      for (int i = 0; i < 300 && !got; i++) begin
         @(negedge CLK);
         if (req_ready[lane]) got = 1'b1;
         else step(1);
      end
      if (!got) timeout("grant_wait");
      step(1);
      req_valid[lane] = 1'b0;
   endtask

   task automatic wait_done(input int bound);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < bound && !ok; i++) begin
         @(negedge CLK);
         if (exp_q.size() == 0 && !busy) ok = 1'b1;
      end
      if (!ok) timeout("drain_wait");
      step(1);
   endtask

   // Monitor: compare each newly presented response with the scoreboard head.
   initial begin
      logic [N-1:0] prev_vld;
      exp_t e;
      prev_vld = '0;
      forever begin
         @(negedge CLK);
         if (|(req_valid & req_ready)) acc_cyc = cyc;
         if (rsp_valid != '0 && prev_vld == '0) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_rsp", W'(rsp_valid), '0);
            end else begin
               e = exp_q.pop_front();
               chk("rsp_lane", W'(rsp_valid), W'(4'b0001 << e.lane));
               chk("rsp_quotient", rsp_quotient, e.q);
               chk("rsp_dbz", W'(rsp_div_by_zero), W'(e.dbz));
               chk("rsp_latency", W'(cyc - acc_cyc), W'(e.lat));
            end
         end
         prev_vld = rsp_valid;
      end
   end

   initial begin
      bit ok;
      int lanes[5] = '{0, 1, 2, 3, 0};
      RESET = 1'b1;
      rsp_ready = '1;
      req_valid = '1;
      req_num = {64'(-81), 64'(1000), 64'(-100), 64'(100)};
      req_den = {64'(-9),  64'(-10),  64'(7),    64'(7)};
      step(3);
      @(negedge CLK);
      chk("reset_req_ready", W'(req_ready), '0);
      chk("reset_rsp_valid", W'(rsp_valid), '0);
      chk("reset_quotient", rsp_quotient, '0);
      chk("reset_dbz", W'(rsp_div_by_zero), '0);
      chk("reset_busy", W'(busy), '0);

      // All lanes requesting continuously from reset release.
      push(0, 64'(14), 1'b0);
      push(1, 64'(-14), 1'b0);
      push(2, 64'(-100), 1'b0);
      push(3, 64'(9), 1'b0);
      push(0, 64'(14), 1'b0);
      step(1);
      RESET = 1'b0;
      for (int g = 0; g < 5; g++) begin
         ok = 1'b0;
         for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge CLK);
            if (|req_ready) ok = 1'b1;
         end
         if (!ok) timeout("rr_grant_wait");
         chk("rr_grant_order", W'(req_ready), W'(4'b0001 << lanes[g]));
         @(posedge CLK);
      end
      #1;
      req_valid = '0;
      wait_done(400);

      issue(0, 64'(100), 64'(7), 64'(14), 1'b0, 1'b1);   wait_done(200);
      issue(0, 64'(-100), 64'(7), 64'(-14), 1'b0, 1'b1); wait_done(200);
      issue(0, 64'(100), 64'(-7), 64'(-14), 1'b0, 1'b1); wait_done(200);
      issue(0, 64'(-100), 64'(-7), 64'(14), 1'b0, 1'b1); wait_done(200);
      issue(2, 64'(5), 64'(0), 64'(0), 1'b1, 1'b1);       wait_done(200);
      issue(1, MIN, NEG1, MIN, 1'b0, 1'b1);                wait_done(200);
      issue(1, 64'(7), MIN, 64'(0), 1'b0, 1'b1);           wait_done(200);
      issue(1, MIN, 64'(1), MIN, 1'b0, 1'b1);              wait_done(200);

      // Held response: only the owning lane's rsp_ready releases it.
      rsp_ready = 4'b0111;
      issue(3, 64'(1000), 64'(-3), 64'(-333), 1'b0, 1'b1);
      ok = 1'b0;
      for (int i = 0; i < 200 && !ok; i++) begin
         @(negedge CLK);
         if (rsp_valid != '0) ok = 1'b1;
      end
      if (!ok) timeout("hold_rsp_wait");
      step(1);
      req_num[1*W +: W] = 64'(-50);
      req_den[1*W +: W] = 64'(4);
      req_valid[1] = 1'b1;
      push(1, 64'(-12), 1'b0);
      for (int i = 0; i < 20; i++) begin
         @(negedge CLK);
         chk("hold_rsp_valid", W'(rsp_valid), W'(4'b1000));
         chk("hold_quotient", rsp_quotient, 64'(-333));
         chk("hold_req_ready", W'(req_ready), '0);
         step(1);
      end
      rsp_ready = 4'b1000;
      @(negedge CLK);
      chk("release_cycle_rsp", W'(rsp_valid), W'(4'b1000));
      step(1);
      @(negedge CLK);
      chk("grant_after_release", W'(req_ready), W'(4'b0010));
      step(1);
      req_valid[1] = 1'b0;
      rsp_ready = '1;
      wait_done(200);

      // Reset in the middle of CALC abandons the operation.
      issue(0, 64'(123), 64'(5), 64'(0), 1'b0, 1'b0);
      step(29);
      RESET = 1'b1;
      @(negedge CLK);
      chk("busy_before_reset", W'(busy), 64'(1));
      step(1);
      RESET = 1'b0;
      @(negedge CLK);
      chk("abort_outputs", {W'(req_ready), W'(rsp_valid), W'(busy)} == '0 ? 64'(0) : 64'(1), 64'(0));
      chk("abort_quotient", rsp_quotient, '0);
      chk("abort_dbz", W'(rsp_div_by_zero), '0);
      ok = 1'b1;
      for (int i = 0; i < 80; i++) begin
         @(negedge CLK);
         if (rsp_valid != '0) ok = 1'b0;
      end
      chk("no_stale_rsp", W'(ok), 64'(1));
      step(1);
      issue(0, 64'(9), 64'(3), 64'(3), 1'b0, 1'b1);
      wait_done(200);

      chk("scoreboard_empty", W'(exp_q.size()), '0);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: cycle %0d", cyc);
      $fatal(1);
   end

endmodule
